sdram_read_frame: RTL and testbench

//  Avalon-MM burst-read master that fetches one video frame from a DDR frame buffer.

---
 rtl/sdram_pkg.sv | 8 +
 rtl/sdram_ifc.sv | 16 +
 rtl/read_word_fifo.sv | 49 ++++
 rtl/sdram_read_frame.sv | 146 ++++++++++++++
 tb/tb_sdram_read_frame.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared widths and read-FSM state encoding for the frame-buffer read path.
package sdram_pkg;
  localparam int PIX_W  = 24;
  localparam int WORD_W = 64;
  localparam int ADDR_W = 29;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} rd_state_t;
endpackage

// File: rtl/sdram_ifc.sv
// Avalon-MM burst-read port towards the HPS f2h_sdram bridge.
interface sdram_ifc;
  import sdram_pkg::*;
  logic [ADDR_W-1:0] address;
  logic [7:0]        burstcount;
  logic              read;
  logic              waitrequest;
  logic [WORD_W-1:0] readdata;
  logic              readdatavalid;
  logic [7:0]        byteenable;

  modport sdram_read_master_port (
    output address, burstcount, read, byteenable,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/read_word_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head word while not empty.
module read_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk_100,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign usedw   = count;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_100) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sdram_read_frame.sv
// Burst-read master fetching one frame from DDR and streaming it as 24-bit RGB pixels.
module sdram_read_frame
  import sdram_pkg::*;
#(
  parameter int H_RES      = 1280,
  parameter int V_RES      = 720,
  parameter int BURST_LEN  = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        start_frame,
  input  logic        buf_sel,
  input  logic [31:0] reg_addr_buf_1,
  input  logic [31:0] reg_addr_buf_2,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        overflow,
  sdram_ifc.sdram_read_master_port f2h_sdram1
);
  localparam int NUM_BURSTS = H_RES * V_RES / 2 / BURST_LEN;
  localparam int BIDX_W     = $clog2(NUM_BURSTS + 1);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int XW         = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW         = (V_RES > 1) ? $clog2(V_RES) : 1;

  rd_state_t         state, state_nxt;
  logic [ADDR_W-1:0] base_addr;
  logic [BIDX_W-1:0] burst_idx;
  logic [CNT_W-1:0]  outstanding;
  logic              phase;
  logic [XW-1:0]     x_pos;
  logic [YW-1:0]     y_pos;

  logic [WORD_W-1:0] fifo_q;
  logic [CNT_W-1:0]  fifo_used;
  logic              fifo_empty, fifo_full;

  logic              start_ok, burst_acc, last_burst, beat_ok, credit_ok;
  logic              pix_accept, x_last, y_last, frame_end;
  logic [CNT_W:0]    committed;
  logic [31:0]       pix_word;
  logic              unused_bits;

  assign start_ok   = start_frame && (state == IDLE);
  assign burst_acc  = (state == ISSUE) && !f2h_sdram1.waitrequest;
  assign last_burst = (burst_idx == BIDX_W'(NUM_BURSTS - 1));
  // Beats are taken only inside a frame so stale data after an abort is dropped.
  assign beat_ok    = f2h_sdram1.readdatavalid && (state != IDLE);
  assign committed  = (CNT_W+1)'(fifo_used) + (CNT_W+1)'(outstanding);
  assign credit_ok  = committed <= (CNT_W+1)'(FIFO_DEPTH - BURST_LEN);
  assign pix_accept = pix_valid && pix_ready;
  assign x_last     = (x_pos == XW'(H_RES - 1));
  assign y_last     = (y_pos == YW'(V_RES - 1));
  assign frame_end  = pix_accept && x_last && y_last;

  assign f2h_sdram1.read       = (state == ISSUE);
  assign f2h_sdram1.address    = base_addr + ADDR_W'(burst_idx) * ADDR_W'(BURST_LEN);
  assign f2h_sdram1.burstcount = 8'(BURST_LEN);
  assign f2h_sdram1.byteenable = 8'hFF;

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_frame) state_nxt = ISSUE;
      ISSUE:   if (!f2h_sdram1.waitrequest) state_nxt = last_burst ? DRAIN : WAIT;
      WAIT:    if (credit_ok) state_nxt = ISSUE;
      DRAIN:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      base_addr   <= '0;
      burst_idx   <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      phase       <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
    end else if (start_ok) begin
      base_addr   <= buf_sel ? reg_addr_buf_2[ADDR_W-1:0] : reg_addr_buf_1[ADDR_W-1:0];
      burst_idx   <= '0;
      outstanding <= '0;
      busy        <= 1'b1;
      overflow    <= 1'b0;
      phase       <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
    end else begin
      if (burst_acc) burst_idx <= burst_idx + 1'b1;
      outstanding <= outstanding
                   + (burst_acc ? CNT_W'(BURST_LEN) : CNT_W'(0))
                   - ((beat_ok && outstanding != '0) ? CNT_W'(1) : CNT_W'(0));
      if (beat_ok && fifo_full) overflow <= 1'b1;
      if (pix_accept) begin
        phase <= ~phase;
        if (x_last) begin
          x_pos <= '0;
          y_pos <= y_last ? '0 : y_pos + 1'b1;
        end else begin
          x_pos <= x_pos + 1'b1;
        end
      end
      if (frame_end) busy <= 1'b0;
    end
  end

  read_word_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_100 (clk_100),
    .reset_n (reset_n),
    .wr_en   (beat_ok),
    .wr_data (f2h_sdram1.readdata),
    .rd_en   (pix_accept && phase),
    .rd_data (fifo_q),
    .usedw   (fifo_used),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Word packs two {8'd0,b,g,r} pixels, low half first.
  assign pix_word  = phase ? fifo_q[63:32] : fifo_q[31:0];
  assign pix_valid = !fifo_empty;
  assign r_out     = pix_valid ? pix_word[7:0]   : 8'd0;
  assign g_out     = pix_valid ? pix_word[15:8]  : 8'd0;
  assign b_out     = pix_valid ? pix_word[23:16] : 8'd0;
  assign sof       = pix_valid && (x_pos == '0) && (y_pos == '0) && !phase;
  assign eol       = pix_valid && x_last;
  assign eof       = pix_valid && x_last && y_last;

  assign unused_bits = ^{reg_addr_buf_1[31:ADDR_W], reg_addr_buf_2[31:ADDR_W], pix_word[31:PIX_W]};
endmodule

// File: tb/tb_sdram_read_frame.sv
// Directed bench: Avalon read slave model plus pixel stream checker for sdram_read_frame.
module tb_sdram_read_frame;
  localparam int H_RES = 8, V_RES = 4, BURST_LEN = 8, FIFO_DEPTH = 16, NPIX = 32;

  logic        clk_100 = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_frame = 1'b0;
  logic        buf_sel = 1'b0;
  logic        pix_ready = 1'b0;
  logic [31:0] addr1 = 32'h100;
  logic [31:0] addr2 = 32'h2000;
  logic [7:0]  r_out, g_out, b_out;
  logic        pix_valid, sof, eol, eof, busy, overflow;

  sdram_ifc mem_if();

  sdram_read_frame #(.H_RES(H_RES), .V_RES(V_RES), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_100        (clk_100),
    .reset_n        (reset_n),
    .start_frame    (start_frame),
    .buf_sel        (buf_sel),
    .reg_addr_buf_1 (addr1),
    .reg_addr_buf_2 (addr2),
    .r_out          (r_out),
    .g_out          (g_out),
    .b_out          (b_out),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .sof            (sof),
    .eol            (eol),
    .eof            (eof),
    .busy           (busy),
    .overflow       (overflow),
    .f2h_sdram1     (mem_if)
  );

  always #5 clk_100 = ~clk_100;

  int          checks = 0, fails = 0;
  int          pix_idx = 0, words_in = 0, popped = 0, max_commit = 0, commit_now = 0;
  int          wait_n = 0, ready_mode = 0, ready_hold = 0, wr_cnt = 0, n_word = 0;
  bit          gap_en = 0, prev_wait = 0, prev_stall = 0;
  logic [28:0] cur_base = 29'h0, prev_addr = 29'h0, beat_addr;
  logic [28:0] burst_log[$];
  logic [28:0] pending[$];
  logic [31:0] exp_pix;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix32(input int k);
    logic [7:0] v;
    v = k[7:0];
    return {8'd0, v + 8'h10, v ^ 8'hA5, v};
  endfunction

  // Memory slave and stream monitor: drive at negedge, observe 1 unit later.
  always @(negedge clk_100) begin
    if (!reset_n) begin
      pending.delete();
      mem_if.waitrequest   = 1'b0;
      mem_if.readdatavalid = 1'b0;
      mem_if.readdata      = 64'd0;
      pix_ready  = 1'b0;
      wr_cnt     = 0;
      prev_wait  = 0;
      prev_stall = 0;
    end else begin
      if (mem_if.read && wr_cnt < wait_n) begin
        mem_if.waitrequest = 1'b1;
        wr_cnt++;
      end else begin
        mem_if.waitrequest = 1'b0;
      end
      if (pending.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        beat_addr = pending.pop_front();
        n_word = int'(beat_addr - cur_base);
        mem_if.readdata      = {pix32(2 * n_word + 1), pix32(2 * n_word)};
        mem_if.readdatavalid = 1'b1;
        words_in++;
      end else begin
        mem_if.readdatavalid = 1'b0;
      end
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom_range(0, 1));
        default: begin
          pix_ready = (ready_hold == 0);
          if (ready_hold > 0) ready_hold--;
        end
      endcase
      #1;
      if (prev_wait)
        check("req_stable", {mem_if.read, mem_if.address, mem_if.burstcount}, {1'b1, prev_addr, 8'(BURST_LEN)});
      prev_wait = mem_if.read && mem_if.waitrequest;
      prev_addr = mem_if.address;
      if (mem_if.read && !mem_if.waitrequest) begin
        burst_log.push_back(mem_if.address);
        for (int i = 0; i < BURST_LEN; i++) pending.push_back(mem_if.address + 29'(i));
        wr_cnt = 0;
      end
      if (prev_stall && busy) check("valid_held", pix_valid, 1'b1);
      prev_stall = pix_valid && !pix_ready;
      if (pix_valid && pix_ready) begin
        exp_pix = pix32(pix_idx);
        check($sformatf("pixel%0d", pix_idx), {r_out, g_out, b_out, sof, eol, eof},
              {exp_pix[7:0], exp_pix[15:8], exp_pix[23:16], pix_idx == 0,
               (pix_idx % H_RES) == H_RES - 1, pix_idx == NPIX - 1});
        pix_idx++;
        if (pix_idx % 2 == 0) popped++;
      end
      commit_now = words_in - popped + pending.size();
      if (commit_now > max_commit) max_commit = commit_now;
    end
  end

  task automatic run_frame(input string name, input bit sel, input logic [28:0] base,
                           input int wn, input bit gaps, input int rmode, input int restart_at);
    wait_n = wn; gap_en = gaps; ready_mode = rmode; ready_hold = 40; cur_base = base;
    pix_idx = 0; words_in = 0; popped = 0; max_commit = 0;
    burst_log.delete();
    @(negedge clk_100);
    buf_sel = sel;
    start_frame = 1'b1;
    @(negedge clk_100);
    start_frame = 1'b0;
    buf_sel = ~sel;
    for (int c = 0; c < 3000 && !(pix_idx == NPIX && !busy); c++) begin
      @(negedge clk_100);
      start_frame = (c == restart_at);
    end
    start_frame = 1'b0;
    #2;
    check({name, "_pix_count"}, pix_idx, NPIX);
    check({name, "_burst_count"}, burst_log.size(), 2);
    if (burst_log.size() >= 2)
      check({name, "_burst_addr"}, {burst_log[0], burst_log[1]}, {base, base + 29'(BURST_LEN)});
    check({name, "_busy_done"}, busy, 1'b0);
    check({name, "_overflow"}, overflow, 1'b0);
    check({name, "_commit_le_depth"}, max_commit <= FIFO_DEPTH, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", checks - fails, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_100);
    #1;
    check("reset_outs", {mem_if.read, pix_valid, busy, overflow, sof, eol, eof, r_out, g_out, b_out}, '0);
    check("reset_req", {mem_if.address, mem_if.burstcount}, {29'h0, 8'(BURST_LEN)});
    reset_n = 1'b1;
    repeat (3) @(negedge clk_100);
    #1;
    check("idle_outs", {mem_if.read, pix_valid, busy, mem_if.byteenable}, {3'b000, 8'hFF});

    run_frame("t1_basic", 1'b0, 29'h100, 0, 1'b0, 0, -1);
    run_frame("t2_waitreq", 1'b1, 29'h2000, 5, 1'b0, 0, -1);
    run_frame("t3_backpressure", 1'b0, 29'h100, 0, 1'b0, 2, -1);
    run_frame("t4_random", 1'b0, 29'h100, 0, 1'b1, 1, -1);
    run_frame("t5_restart", 1'b0, 29'h100, 0, 1'b0, 1, 10);

    // Abort during the second burst's data, then recover with a clean frame.
    wait_n = 0; gap_en = 1'b1; ready_mode = 0; cur_base = 29'h100;
    pix_idx = 0; words_in = 0; popped = 0;
    burst_log.delete();
    @(negedge clk_100);
    buf_sel = 1'b0;
    start_frame = 1'b1;
    @(negedge clk_100);
    start_frame = 1'b0;
    for (int c = 0; c < 500 && burst_log.size() < 2; c++) @(negedge clk_100);
    check("t6_second_burst_seen", burst_log.size(), 2);
    @(negedge clk_100);
    reset_n = 1'b0;
    #1;
    check("t6_async_reset_outs",
          {mem_if.read, pix_valid, busy, overflow, sof, eol, eof, r_out, g_out, b_out}, '0);
    check("t6_async_reset_addr", mem_if.address, 29'h0);
    repeat (3) @(negedge clk_100);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_100);
    #1;
    check("t6_idle_after_reset", {pix_valid, busy, mem_if.read}, 3'b000);
    run_frame("t6_clean", 1'b0, 29'h100, 0, 1'b0, 0, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
